csa_rr_sched: RTL and testbench

// - Round-robin scheduler sharing one simp_pipe_csa_N adder pipeline among NUM_REQ requesters.
// - Each requester offers one INPUT_VEC_LEN x WIDTH operand vector per transaction.
// - Tags each issued vector with its requester ID and tracks it through the fixed pipe latency.
// - Buffers sums in a result FIFO and returns them in issue order with the ID.
// - Credit scheme: the pipe has no stall input, so issue is only allowed when FIFO space is guaranteed.

---
 rtl/dpe_sched_pkg.sv | 20 ++
 rtl/csa_rr_sched_res_fifo.sv | 60 ++++++
 rtl/csa_rr_sched.sv | 140 ++++++++++++++
 tb/tb_csa_rr_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpe_sched_pkg.sv
// dpe_sched_pkg
// Shared constants and types for the CSA round-robin scheduler.
//   WIDTH, INPUT_VEC_LEN : operand element width and vector length of the
//                          shared simp_pipe_csa_N adder (DPE datapath values)
//   NUM_REQ              : number of requesters sharing the adder
//   REQ_ID_W             : width of a requester id
//   csa_tag_t            : {valid, id} travelling alongside each vector in the pipe
package dpe_sched_pkg;

  localparam int WIDTH         = 16;
  localparam int INPUT_VEC_LEN = 4;
  localparam int NUM_REQ       = 4;
  localparam int REQ_ID_W      = $clog2(NUM_REQ);

  typedef struct packed {
    logic                v;
    logic [REQ_ID_W-1:0] id;
  } csa_tag_t;

endpackage

// File: rtl/csa_rr_sched_res_fifo.sv
// res_fifo
// Synchronous result FIFO with an occupancy count. The head entry is shown
// combinationally; the head data reads as zero while the FIFO is empty.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data : write an entry at the tail
//   pop             : remove the head entry (ignored while empty)
//   head_valid      : FIFO not empty
//   head_data       : head entry
//   count           : number of stored entries, 0..DEPTH
module res_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [DW-1:0]              head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap explicitly so non-power-of-two depths work too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  // Keeps CW referenced for the count width check.
  logic unused_cw_ok;
  assign unused_cw_ok = (CW == $bits(count));

endmodule

// File: rtl/csa_rr_sched.sv
// csa_rr_sched
// Round-robin scheduler that shares one fixed-latency CSA adder pipe among
// NUM_REQ requesters. Each issued vector is tagged with its requester id. The
// tag travels beside the pipe, and the sum is parked in a result FIFO that
// returns results in issue order. The pipe cannot stall, so a vector is only
// issued when a FIFO slot is already reserved for its result (credit).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester vector pending
//   req_data   : per-requester operand vectors
//   req_ready  : one-hot grant; a transfer happens on valid & ready
//   csa_in     : operands to the adder pipe (zero when not issuing)
//   csa_c_in   : adder carry-in, tied 0
//   csa_s      : adder pipe sum output
//   res_valid, res_ready, res_data, res_id : result stream (FIFO head)
//   busy       : work in flight or results waiting
module csa_rr_sched
  import dpe_sched_pkg::*;
#(
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            req_valid,
  input  logic [NUM_REQ-1:0][INPUT_VEC_LEN-1:0][WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                            req_ready,
  output logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]           csa_in,
  output logic                                          csa_c_in,
  input  logic [WIDTH-1:0]                              csa_s,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic [WIDTH-1:0]                              res_data,
  output logic [REQ_ID_W-1:0]                           res_id,
  output logic                                          busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int ENT_W = WIDTH + REQ_ID_W;

  logic [REQ_ID_W-1:0] rr_ptr;
  logic [REQ_ID_W-1:0] grant_id;
  logic [REQ_ID_W-1:0] scan_idx;
  logic                found;
  logic                issue;
  int                  inflight;
  logic                tag_any;
  csa_tag_t            tag_pipe [PIPE_LAT];

  logic                push;
  logic [ENT_W-1:0]    push_data;
  logic                pop;
  logic                head_valid;
  logic [ENT_W-1:0]    head_data;
  logic [CNT_W-1:0]    fifo_count;

  assign csa_c_in = 1'b0;

  // Rotating priority scan: the first valid requester at or after rr_ptr wins.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = REQ_ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found    = 1'b1;
        grant_id = scan_idx;
      end
    end
  end

  // Every tag in the pipe already owns a FIFO slot. An issue is therefore
  // only safe while stored results plus in-flight tags leave room.
  always_comb begin
    inflight = 0;
    tag_any  = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + int'(tag_pipe[i].v);
      tag_any  = tag_any | tag_pipe[i].v;
    end
    issue = found && ((int'(fifo_count) + inflight) < FIFO_DEPTH);
  end

  always_comb begin
    req_ready = '0;
    csa_in    = '0;
    if (issue) begin
      req_ready[grant_id] = 1'b1;
      csa_in              = req_data[grant_id];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant_id == REQ_ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipe mirrors the adder latency. Clearing it on reset is what makes
  // any sums still draining out of the adder be ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{v: issue, id: grant_id};
      for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign push      = tag_pipe[PIPE_LAT-1].v;
  assign push_data = {tag_pipe[PIPE_LAT-1].id, csa_s};
  assign pop       = head_valid & res_ready;

  res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (ENT_W)
  ) u_res_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign res_valid = head_valid;
  assign res_data  = head_data[WIDTH-1:0];
  assign res_id    = head_data[WIDTH +: REQ_ID_W];
  assign busy      = tag_any | (fifo_count != '0);

  // The credit scheme must never let a result arrive at a full FIFO.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (fifo_count == CNT_W'(FIFO_DEPTH)) && !pop));

endmodule

// File: tb/tb_csa_rr_sched.sv
// tb_csa_rr_sched
// Directed scenarios with random operand data. Each result is predicted by a
// transaction-level model: a queue of issued-but-unconsumed results, where
// credit is simply queue size versus FIFO depth. The adder pipe is emulated
// here as a PIPE_LAT-deep register chain of vector sums.
module tb_csa_rr_sched;
  import dpe_sched_pkg::*;

  localparam int PIPE_LAT   = 2;
  localparam int FIFO_DEPTH = 4;

  logic                                             clk = 1'b0;
  logic                                             rst;
  logic [NUM_REQ-1:0]                               req_valid;
  logic [NUM_REQ-1:0][INPUT_VEC_LEN-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                               req_ready;
  logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]              csa_in;
  logic                                             csa_c_in;
  logic [WIDTH-1:0]                                 csa_s;
  logic                                             res_valid;
  logic                                             res_ready;
  logic [WIDTH-1:0]                                 res_data;
  logic [REQ_ID_W-1:0]                              res_id;
  logic                                             busy;

  csa_rr_sched #(
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .csa_in    (csa_in),
    .csa_c_in  (csa_c_in),
    .csa_s     (csa_s),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] vec_sum(input logic [INPUT_VEC_LEN-1:0][WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    s = '0;
    for (int k = 0; k < INPUT_VEC_LEN; k++) s = s + v[k];
    return s;
  endfunction

  // Adder pipe stand-in, deliberately not reset so stale sums keep arriving.
  logic [WIDTH-1:0] pipe_s [PIPE_LAT];
  always @(posedge clk) begin
    pipe_s[0] <= vec_sum(csa_in);
    for (int i = 1; i < PIPE_LAT; i++) pipe_s[i] <= pipe_s[i-1];
  end
  assign csa_s = pipe_s[PIPE_LAT-1];

  typedef struct {
    int               id;
    logic [WIDTH-1:0] sum;
    int               ready_at;
  } exp_t;

  exp_t exp_q[$];
  int   m_ptr;
  int   edges;
  int   checks;
  int   errors;
  int   obs_issues;
  int   exp_grant;
  logic exp_issue;
  logic exp_pop;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic rr);
    req_valid = v;
    res_ready = rr;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < INPUT_VEC_LEN; k++)
        req_data[i][k] = WIDTH'($urandom);
  endtask

  // Predicts this cycle's grant/result from the model and compares outputs.
  task automatic checkOutput();
    logic [NUM_REQ-1:0]                  exp_ready;
    logic [INPUT_VEC_LEN-1:0][WIDTH-1:0] exp_in;
    logic                                exp_rv;
    #1;
    exp_grant = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (exp_grant < 0 && req_valid[i]) exp_grant = i;
    end
    exp_issue = (exp_grant >= 0) && (exp_q.size() < FIFO_DEPTH);
    exp_ready = '0;
    exp_in    = '0;
    if (exp_issue) begin
      exp_ready[exp_grant] = 1'b1;
      exp_in               = req_data[exp_grant];
    end
    exp_rv  = (exp_q.size() > 0) && (edges >= exp_q[0].ready_at);
    exp_pop = exp_rv && res_ready;
    checkVal("req_ready", 128'(req_ready), 128'(exp_ready));
    checkVal("csa_in",    128'(csa_in),    128'(exp_in));
    checkVal("csa_c_in",  128'(csa_c_in),  128'(1'b0));
    checkVal("res_valid", 128'(res_valid), 128'(exp_rv));
    checkVal("busy",      128'(busy),      128'(exp_q.size() != 0));
    if (exp_rv) begin
      checkVal("res_data", 128'(res_data), 128'(exp_q[0].sum));
      checkVal("res_id",   128'(res_id),   128'(exp_q[0].id));
    end
    if (req_ready != '0) obs_issues++;
  endtask

  task automatic cycle(input logic [NUM_REQ-1:0] v, input logic rr);
    applyStimulus(v, rr);
    checkOutput();
    @(posedge clk);
    if (exp_pop) void'(exp_q.pop_front());
    if (exp_issue) begin
      exp_q.push_back('{id: exp_grant, sum: vec_sum(req_data[exp_grant]),
                        ready_at: edges + 1 + PIPE_LAT});
      m_ptr = (exp_grant + 1) % NUM_REQ;
    end
    edges++;
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    for (int c = 0; c < n; c++) begin
      #1;
      checkVal("rst_req_ready", 128'(req_ready), 128'(0));
      checkVal("rst_res_valid", 128'(res_valid), 128'(0));
      checkVal("rst_busy",      128'(busy),      128'(0));
      checkVal("rst_res_data",  128'(res_data),  128'(0));
      checkVal("rst_res_id",    128'(res_id),    128'(0));
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    edges  = 0;
    obs_issues = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;

    // Reset then idle
    doReset(3);
    for (int c = 0; c < 4; c++) cycle('0, 1'b1);

    // Single issue from requester 2 with all-ones operands
    applyStimulus(4'b0100, 1'b0);
    for (int k = 0; k < INPUT_VEC_LEN; k++) req_data[2][k] = WIDTH'(1);
    #1;
    checkVal("single_grant", 128'(req_ready), 128'(4'b0100));
    checkOutput();
    @(posedge clk);
    if (exp_issue) begin
      exp_q.push_back('{id: exp_grant, sum: vec_sum(req_data[exp_grant]),
                        ready_at: edges + 1 + PIPE_LAT});
      m_ptr = (exp_grant + 1) % NUM_REQ;
    end
    edges++;
    @(negedge clk);
    cycle('0, 1'b0);
    cycle('0, 1'b0);
    #1;
    checkVal("single_res_valid", 128'(res_valid), 128'(1));
    checkVal("single_res_data",  128'(res_data),  128'(4));
    checkVal("single_res_id",    128'(res_id),    128'(2));
    for (int c = 0; c < 3; c++) cycle('0, 1'b1);

    // Round-robin at full throughput from a fresh pointer
    doReset(1);
    obs_issues = 0;
    for (int c = 0; c < 12; c++) cycle('1, 1'b1);
    checkVal("rr_issue_count", 128'(obs_issues), 128'(12));
    for (int c = 0; c < 5; c++) cycle('0, 1'b1);

    // Backpressure: credit stops issue at FIFO depth, one pop frees one slot
    obs_issues = 0;
    for (int c = 0; c < 8; c++) cycle('1, 1'b0);
    checkVal("bp_issue_count", 128'(obs_issues), 128'(FIFO_DEPTH));
    obs_issues = 0;
    cycle('1, 1'b1);
    for (int c = 0; c < 4; c++) cycle('1, 1'b0);
    checkVal("bp_extra_issue", 128'(obs_issues), 128'(1));
    for (int c = 0; c < 8; c++) cycle('0, 1'b1);

    // Push and pop in the same cycle with three entries stored
    for (int c = 0; c < 3; c++) cycle(4'b0001, 1'b0);
    for (int c = 0; c < 3; c++) cycle('0, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle('0, 1'b0);
    cycle('0, 1'b1);
    obs_issues = 0;
    for (int c = 0; c < 3; c++) cycle('1, 1'b0);
    checkVal("pp_credit_issue", 128'(obs_issues), 128'(1));
    for (int c = 0; c < 8; c++) cycle('0, 1'b1);

    // Reset with two results stored and two still in the pipe
    for (int c = 0; c < 4; c++) cycle('1, 1'b0);
    doReset(1);
    for (int c = 0; c < 5; c++) cycle('0, 1'b1);

    // Random traffic
    for (int c = 0; c < 40; c++)
      cycle(NUM_REQ'($urandom), 1'($urandom_range(0, 1)));
    for (int c = 0; c < 8; c++) cycle('0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
